mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the team's 4:1 gate-level mux among 4 requesters.
//  Grants one requester at a time and drives the mux selects.
//  Wiring: S1 = sel[1], S0 = sel[0]; requester k maps to mux input Ik.
//  Bounds each tenure to MAX_HOLD transfers and passes downstream backpressure through.
// PARAMETERS
//  MAX_HOLD  4  transfers per grant before forced rotation; legal range >= 1
//  CNT_W     $clog2(MAX_HOLD+1)  localparam, hold-counter width; not overridable
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  req        in   4  per-requester request; bit k = requester k
//  out_ready  in   1  downstream accepts the muxed bit this cycle
//  grant      out  4  one-hot registered grant; 0000 = none
//  sel        out  2  registered mux select = index of current/last grantee
//  out_valid  out  1  combinational: |(grant & req)
//  busy       out  1  registered: state == GRANT
// BEHAVIOUR
//  Reset (async, immediate on rst_n=0): all state and outputs cleared.
//   - state=IDLE, grant=0000, sel=00, ptr=0, cnt=0, busy=0
//   - out_valid=0
//   - Reset mid-tenure drops grant in the same instant; no transfer is counted.
//  Arbitration pick (combinational):
//   - Winner = first k with req[k]=1, scanning ptr, ptr+1, ... (mod 4).
//   - Excluded index (if any): considered last.
//  States: IDLE, GRANT.
//   IDLE
//    - If |req: next edge -> GRANT, grant=onehot(winner), sel=winner, cnt=0.
//    - Latency: req rises in cycle N -> grant and sel valid in cycle N+1.
//    - Else: stay IDLE; sel holds its last value so the mux does not toggle.
//   GRANT (g = current grantee)
//    - Transfer = out_valid & out_ready; on transfer cnt += 1.
//    - out_ready=0 or out_valid=0 -> no count; grant held.
//    - No timeout while req[g]=1 and no transfer occurs.
//    - Release conditions:
//      (a) req[g]=0
//      (b) transfer with cnt == MAX_HOLD-1
//    - On release: ptr <= (g+1) mod 4.
//    - After release, next edge re-arbitrates with g excluded:
//      - Another requester pending -> grant it directly, no idle bubble, cnt=0.
//      - Only g pending (case b) -> re-grant g, cnt=0.
//      - Nothing pending -> IDLE, grant=0000.
//  Invariants (checkable):
//   - grant is one-hot or zero.
//   - grant != 0 implies sel == index(grant).
//   - Starvation bound: a held req is granted within 3*MAX_HOLD transfers
//     (plus any backpressure stalls).
//  Simultaneous events: req[g] falling on the same cycle as a last-count
//  transfer is one release event; ptr advances once.
//  sel changes only on grant-change edges, so the mux output is stable
//  within a tenure.
// STRUCTURE
//  Package mux_arb_pkg:
//   - NUM_REQ=4, SEL_W=2
//   - typedef enum logic {IDLE, GRANT} arb_state_t
//   - function onehot2idx
//  Sub-module rr_pick (combinational):
//   - Inputs: req[3:0], ptr[1:0], excl_en, excl_idx[1:0]
//   - Outputs: found, idx[1:0]
//   - Implementation: rotate, priority-encode, un-rotate.
//  Top: state register, ptr/cnt/grant/sel registers, release logic.
//  The mux itself is not instantiated here; sel is wired to the mux at integration.
// TESTING
//  1 rst_n=0 in any state, any req
//    -> grant=0000, sel=00, busy=0, out_valid=0, asynchronously
//  2 req=0100 from cycle 1, out_ready=1
//    -> cycle 2: grant=0100, sel=10, out_valid=1
//    -> 4 transfers, then re-grant 0100 with cnt=0
//  3 req=1111 held, out_ready=1, MAX_HOLD=4
//    -> grants 0001,0010,0100,1000,0001; 4 transfers each
//    -> back-to-back tenures, no IDLE cycle
//  4 grant=0010 after 1 transfer; req becomes 1001
//    -> next edge grant=1000, sel=11, ptr=2 at release
//  5 grant=0001, req=0011, out_ready=0 for 20 cycles
//    -> grant stays 0001, cnt stays 0
//    -> after out_ready=1: 4 transfers, then grant=0010
//  6 req drops to 0000 in GRANT with sel=01
//    -> IDLE, grant=0000, sel stays 01, busy=0

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter that drives the 4:1 mux selects.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | SEL_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: scan from ptr upward (mod 4); an excluded
// index loses to every other requester and only wins when it is the sole one.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic               excl_en,
  input  logic [SEL_W-1:0]   excl_idx,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] excl_mask;
  logic [NUM_REQ-1:0] req_m;
  logic [NUM_REQ-1:0] req_rot;
  logic               found_rot;
  logic [SEL_W-1:0]   off_rot;

  assign excl_mask = excl_en ? idx2onehot(excl_idx) : '0;
  assign req_m     = req & ~excl_mask;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [SEL_W-1:0] src_idx;
      assign src_idx     = ptr + SEL_W'(gi);
      assign req_rot[gi] = req_m[src_idx];
    end
  endgenerate

  // Lowest rotated position wins; scanning downward leaves the lowest hit.
  always_comb begin
    found_rot = 1'b0;
    off_rot   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found_rot = 1'b1;
        off_rot   = SEL_W'(i);
      end
    end
  end

  assign found = found_rot | (excl_en & req[excl_idx]);
  assign idx   = found_rot ? (ptr + off_rot) : excl_idx;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux; grant and sel are
// registered, tenures are capped at MAX_HOLD transfers and re-arbitrate without a bubble.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q,  busy_d;

  logic [SEL_W-1:0]   cur_idx;
  logic [SEL_W-1:0]   next_ptr;
  logic               in_grant;
  logic               xfer;
  logic               last_xfer;
  logic               release_c;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  assign cur_idx   = onehot2idx(grant_q);
  assign next_ptr  = cur_idx + SEL_W'(1);
  assign in_grant  = (state_q == GRANT);
  assign out_valid = |(grant_q & req);
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer && (cnt_q == CNT_LAST);
  // A dropped request and a last-count transfer in the same cycle form one release.
  assign release_c = in_grant && (!req[cur_idx] || last_xfer);

  // In GRANT the pick is only consumed on release, where ptr is about to become g+1.
  assign pick_ptr  = in_grant ? next_ptr : ptr_q;

  rr_pick u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .excl_en  (in_grant),
    .excl_idx (cur_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = idx2onehot(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      GRANT: begin
        if (release_c) begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (pick_found) begin
            grant_d = idx2onehot(pick_idx);
            sel_d   = pick_idx;
          end else begin
            // sel keeps its value so the mux select does not toggle while idle.
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench: stimulus queues the grant/sel expected on every
// transfer; a negedge monitor pops and compares whenever a transfer occurs.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out_valid;
  logic       busy;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   xfer_no;

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
    checks++;
    if (act !== req_val) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_val);
    end
  endtask

  task automatic push_n(input logic [3:0] g, input logic [1:0] s, input int n);
    exp_t e;
    e.grant = g;
    e.sel   = s;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Leaves the bench 1 ns after the n-th rising edge, so inputs change away from edges.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard compare on each transfer, plus per-cycle grant invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL grant_onehot: got %b, required one-hot or zero", grant);
      end
      if (grant != 4'b0000) begin
        logic [1:0] gi_idx;
        gi_idx = 2'd0;
        for (int i = 0; i < 4; i++) if (grant[i]) gi_idx = 2'(i);
        check("sel_matches_grant", 32'(sel), 32'(gi_idx));
      end
      if (out_valid && out_ready) begin
        xfer_no++;
        $display("xfer %0d grant=%b sel=%0d", xfer_no, grant, sel);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got grant=%b, required no transfer", grant);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("xfer_grant", 32'(grant), 32'(e.grant));
          check("xfer_sel", 32'(sel), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    xfer_no   = 0;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;

    // Reset holds everything cleared even with all requests active.
    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);

    // Single requester 2: latency one cycle, re-granted after every 4 transfers.
    tick(1);
    req   = 4'b0000;
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", 32'(busy), 32'h0);
    push_n(4'b0100, 2'd2, 8);
    req = 4'b0100;
    tick(1);
    check("s2_grant", 32'(grant), 32'b0100);
    check("s2_sel", 32'(sel), 32'd2);
    check("s2_out_valid", 32'(out_valid), 32'h1);
    check("s2_busy", 32'(busy), 32'h1);
    tick(4);
    check("s2_regrant", 32'(grant), 32'b0100);
    tick(4);
    req = 4'b0000;
    tick(1);
    check("s2_idle_grant", 32'(grant), 32'h0);
    check("s2_idle_sel", 32'(sel), 32'd2);
    check("s2_idle_busy", 32'(busy), 32'h0);
    check("s2_q_empty", 32'(exp_q.size()), 32'd0);

    // All four requesting: strict rotation of 4-transfer tenures with no gaps.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    push_n(4'b0001, 2'd0, 4);
    push_n(4'b0010, 2'd1, 4);
    push_n(4'b0100, 2'd2, 4);
    push_n(4'b1000, 2'd3, 4);
    push_n(4'b0001, 2'd0, 4);
    req = 4'b1111;
    tick(1);
    check("s3_first_grant", 32'(grant), 32'b0001);
    tick(20);
    check("s3_q_empty", 32'(exp_q.size()), 32'd0);
    check("s3_next_grant", 32'(grant), 32'b0010);

    // Asynchronous reset mid-tenure clears outputs before any clock edge.
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_sel", 32'(sel), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    tick(1);
    rst_n = 1'b1;

    // Requester 1 drops after one transfer; pointer at 2 makes 3 beat 0.
    push_n(4'b0010, 2'd1, 1);
    req = 4'b0010;
    tick(1);
    check("s4_grant1", 32'(grant), 32'b0010);
    tick(1);
    push_n(4'b1000, 2'd3, 4);
    req = 4'b1001;
    tick(1);
    check("s4_grant3", 32'(grant), 32'b1000);
    check("s4_sel3", 32'(sel), 32'd3);
    tick(4);
    check("s5_grant0", 32'(grant), 32'b0001);

    // Backpressure: 20 stalled cycles neither count nor time out the tenure.
    out_ready = 1'b0;
    req       = 4'b0011;
    push_n(4'b0001, 2'd0, 4);
    push_n(4'b0010, 2'd1, 2);
    tick(20);
    check("s5_stall_grant", 32'(grant), 32'b0001);
    check("s5_stall_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick(4);
    check("s5_rotate_grant", 32'(grant), 32'b0010);
    check("s5_rotate_sel", 32'(sel), 32'd1);
    tick(2);

    // All requests drop while sel=01: idle, and sel keeps pointing at input 1.
    req = 4'b0000;
    tick(1);
    check("s6_grant", 32'(grant), 32'h0);
    check("s6_sel", 32'(sel), 32'd1);
    check("s6_busy", 32'(busy), 32'h0);
    check("s6_out_valid", 32'(out_valid), 32'h0);
    tick(2);
    check("s6_sel_hold", 32'(sel), 32'd1);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
